// File: rtl/afg_reg_pkg.sv
// Purpose: shared types and constants for the double-buffered waveform register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package afg_reg_pkg;

  // Commit sequencer states: waiting for a request, or armed and waiting for sync.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } commit_state_t;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_ADDR_W = 2;

  // Every register in the bank resets to all zeros; replicate this bit to width.
  localparam logic RST_BIT = 1'b0;

endpackage

// File: rtl/reg_bank_chan.sv
// Purpose: one parameter channel -- shadow word, active word and dirty flag.
// Latency: write lands in shadow next cycle; transfer lands in active next cycle.
// Backpressure: none; writes are always accepted.
module reg_bank_chan
  import afg_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              wr_hit,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              xfer,
  output logic [DATA_W-1:0] active,
  output logic              dirty
);

  logic [DATA_W-1:0] shadow;

  // Shadow/active/dirty update; a write on the transfer edge wins the dirty flag
  // while active still takes the pre-write shadow value.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      shadow <= {DATA_W{RST_BIT}};
      active <= {DATA_W{RST_BIT}};
      dirty  <= RST_BIT;
    end else begin
      if (xfer && dirty) begin
        active <= shadow;
      end
      if (wr_hit) begin
        shadow <= wr_data;
        dirty  <= 1'b1;
      end else if (xfer) begin
        dirty  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_bank_dbuf.sv
// Purpose: double-buffered parameter bank; commits all dirty shadows atomically on sync_pulse.
// Latency: dout_flat updates the cycle after the transfer edge; commit_busy the cycle after commit_req.
// Backpressure: none; writes always accepted, commit_req ignored while armed.
// Optional build macro REG_BANK_FORCE_COMMIT_EN adds force_commit (immediate transfer).
module reg_bank_dbuf
  import afg_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     commit_req,
  input  logic                     sync_pulse,
`ifdef REG_BANK_FORCE_COMMIT_EN
  input  logic                     force_commit,
`endif
  output logic                     commit_busy,
  output logic                     commit_done,
  output logic [NUM_CH-1:0]        dirty,
  output logic [NUM_CH*DATA_W-1:0] dout_flat
);

  // One extra bit so NUM_CH itself is representable for the range check.
  localparam logic [ADDR_W:0] NUM_CH_W = (ADDR_W+1)'(NUM_CH);

  commit_state_t state_q, state_d;
  logic          xfer;
  logic [ADDR_W:0] addr_ext;

  assign addr_ext = {1'b0, wr_addr};

  // Next-state and transfer-edge decode.
  always_comb begin
    state_d = state_q;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (sync_pulse) begin
          xfer    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef REG_BANK_FORCE_COMMIT_EN
    if (force_commit) begin
      xfer    = 1'b1;
      state_d = IDLE;
    end
`endif
  end

  // State register plus registered busy/done so outputs never see input paths.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= IDLE;
      commit_busy <= RST_BIT;
      commit_done <= RST_BIT;
    end else begin
      state_q     <= state_d;
      commit_busy <= (state_d == ARMED);
      commit_done <= xfer;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    logic wr_hit;
    assign wr_hit = wr_en && (addr_ext < NUM_CH_W) && (addr_ext == (ADDR_W+1)'(i));

    reg_bank_chan #(.DATA_W(DATA_W)) u_chan (
      .Clock   (Clock),
      .Reset   (Reset),
      .wr_hit  (wr_hit),
      .wr_data (wr_data),
      .xfer    (xfer),
      .active  (dout_flat[i*DATA_W +: DATA_W]),
      .dirty   (dirty[i])
    );
  end

endmodule

// File: tb/tb_reg_bank_dbuf.sv
// Purpose: self-checking bench for reg_bank_dbuf, 4-channel and 3-channel instances side by side.
// Latency: checks outputs 1 time unit after each rising edge against a reference model.
// Backpressure: n/a.
module tb_reg_bank_dbuf;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        commit_req = 1'b0;
  logic        sync_pulse = 1'b0;
  logic        force_commit = 1'b0;

  logic        busy4, done4, busy3, done3;
  logic [3:0]  dirty4;
  logic [2:0]  dirty3;
  logic [47:0] dout4;
  logic [35:0] dout3;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  reg_bank_dbuf #(.DATA_W(12), .NUM_CH(4), .ADDR_W(2)) u_dut4 (
    .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .sync_pulse(sync_pulse),
`ifdef REG_BANK_FORCE_COMMIT_EN
    .force_commit(force_commit),
`endif
    .commit_busy(busy4), .commit_done(done4), .dirty(dirty4), .dout_flat(dout4)
  );

  reg_bank_dbuf #(.DATA_W(12), .NUM_CH(3), .ADDR_W(2)) u_dut3 (
    .Clock(Clock), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_req(commit_req), .sync_pulse(sync_pulse),
`ifdef REG_BANK_FORCE_COMMIT_EN
    .force_commit(force_commit),
`endif
    .commit_busy(busy3), .commit_done(done3), .dirty(dirty3), .dout_flat(dout3)
  );

  // Reference model: index 0 models the 4-channel bank, index 1 the 3-channel bank.
  logic [11:0] m_sh [2][4];
  logic [11:0] m_ac [2][4];
  bit          m_dt [2][4];
  bit          m_armed [2];
  bit          m_done [2];
  int          m_nch [2] = '{4, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge worth of the rules to the model, using the current inputs.
  task automatic model_edge();
    bit xf;
    for (int k = 0; k < 2; k++) begin
      if (!Reset) begin
        for (int c = 0; c < 4; c++) begin
          m_sh[k][c] = '0; m_ac[k][c] = '0; m_dt[k][c] = 0;
        end
        m_armed[k] = 0; m_done[k] = 0;
      end else begin
        xf = m_armed[k] && sync_pulse;
`ifdef REG_BANK_FORCE_COMMIT_EN
        xf = xf || force_commit;
`endif
        if (xf) begin
          for (int c = 0; c < m_nch[k]; c++) begin
            if (m_dt[k][c]) m_ac[k][c] = m_sh[k][c];
            m_dt[k][c] = 0;
          end
        end
        if (wr_en && int'(wr_addr) < m_nch[k]) begin
          m_sh[k][wr_addr] = wr_data;
          m_dt[k][wr_addr] = 1;
        end
        m_done[k] = xf;
        if (xf) m_armed[k] = 0;
        else if (!m_armed[k] && commit_req) m_armed[k] = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [47:0] e4;
    logic [35:0] e3;
    logic [3:0]  d4;
    logic [2:0]  d3;
    for (int c = 0; c < 4; c++) begin
      e4[c*12 +: 12] = m_ac[0][c];
      d4[c] = m_dt[0][c];
    end
    for (int c = 0; c < 3; c++) begin
      e3[c*12 +: 12] = m_ac[1][c];
      d3[c] = m_dt[1][c];
    end
    chk({tag, ".dout4"},  64'(dout4),  64'(e4));
    chk({tag, ".dirty4"}, 64'(dirty4), 64'(d4));
    chk({tag, ".busy4"},  64'(busy4),  64'(m_armed[0]));
    chk({tag, ".done4"},  64'(done4),  64'(m_done[0]));
    chk({tag, ".dout3"},  64'(dout3),  64'(e3));
    chk({tag, ".dirty3"}, 64'(dirty3), 64'(d3));
    chk({tag, ".busy3"},  64'(busy3),  64'(m_armed[1]));
    chk({tag, ".done3"},  64'(done3),  64'(m_done[1]));
  endtask

  // One cycle: inputs already driven; clock, update model, compare, drop strobes.
  task automatic tick(input string tag);
    @(posedge Clock);
    model_edge();
    #1;
    compare_all(tag);
    wr_en = 0; commit_req = 0; sync_pulse = 0; force_commit = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [11:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    logic [47:0] snap;

    // 1. Reset held two cycles, then released.
    Reset = 0;
    tick("rst0");
    tick("rst1");
    Reset = 1;
    tick("rst_rel");
    chk("rst.dout4", 64'(dout4), 64'd0);
    chk("rst.dirty4", 64'(dirty4), 64'd0);
    chk("rst.busy4", 64'(busy4), 64'd0);
    chk("rst.done4", 64'(done4), 64'd0);

    // 2. Basic commit waiting for sync.
    wr(2'd1, 12'hABC); tick("t2.w1");
    wr(2'd3, 12'h123); tick("t2.w3");
    chk("t2.dirty_pre", 64'(dirty4), 64'b1010);
    commit_req = 1; tick("t2.req");
    for (int i = 0; i < 5; i++) begin
      tick("t2.idle");
      chk("t2.busy_wait", 64'(busy4), 64'd1);
    end
    sync_pulse = 1; tick("t2.sync");
    chk("t2.dout", 64'(dout4), 64'({12'h123, 12'h000, 12'hABC, 12'h000}));
    chk("t2.done_hi", 64'(done4), 64'd1);
    chk("t2.busy_lo", 64'(busy4), 64'd0);
    tick("t2.after");
    chk("t2.done_lo", 64'(done4), 64'd0);

    // 3. Write on the transfer edge.
    wr(2'd2, 12'h111); tick("t3.w");
    commit_req = 1; tick("t3.req");
    sync_pulse = 1; wr(2'd2, 12'h555); tick("t3.sync_wr");
    snap = dout4;
    chk("t3.ch2_active", 64'(snap[35:24]), 64'h111);
    chk("t3.dirty", 64'(dirty4), 64'b0100);
    commit_req = 1; tick("t3.req2");
    sync_pulse = 1; tick("t3.sync2");
    snap = dout4;
    chk("t3.ch2_shadow", 64'(snap[35:24]), 64'h555);

    // 4. commit_req with sync in the same IDLE cycle; duplicate request while armed.
    wr(2'd0, 12'h0A5); tick("t4.w");
    commit_req = 1; sync_pulse = 1; tick("t4.req_sync");
    chk("t4.busy", 64'(busy4), 64'd1);
    chk("t4.no_done", 64'(done4), 64'd0);
    commit_req = 1; tick("t4.req_again");
    sync_pulse = 1; tick("t4.sync");
    chk("t4.done", 64'(done4), 64'd1);
    tick("t4.after1");
    chk("t4.single_done", 64'(done4), 64'd0);
    tick("t4.after2");

    // 5. Out-of-range address on the 3-channel bank, then reset while armed.
    wr(2'd3, 12'h777); tick("t5.oob");
    chk("t5.dirty3", 64'(dirty3), 64'd0);
    commit_req = 1; tick("t5.req");
    Reset = 0; tick("t5.rst");
    chk("t5.busy", 64'(busy4), 64'd0);
    chk("t5.done", 64'(done4), 64'd0);
    chk("t5.dout", 64'(dout4), 64'd0);
    Reset = 1; sync_pulse = 1; tick("t5.sync_after");
    chk("t5.no_late_done", 64'(done4), 64'd0);

    // 6. Forced commit without sync.
    wr(2'd0, 12'hFFF); tick("t6.w");
    force_commit = 1; tick("t6.force");
    snap = dout4;
`ifdef REG_BANK_FORCE_COMMIT_EN
    chk("t6.ch0", 64'(snap[11:0]), 64'hFFF);
    chk("t6.done", 64'(done4), 64'd1);
`else
    chk("t6.ch0", 64'(snap[11:0]), 64'h000);
    chk("t6.done", 64'(done4), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      Reset        = ($urandom_range(0, 80) != 0);
      wr_en        = $urandom_range(0, 1) == 1;
      wr_addr      = 2'($urandom_range(0, 3));
      wr_data      = 12'($urandom);
      commit_req   = ($urandom_range(0, 3) == 0);
      sync_pulse   = ($urandom_range(0, 4) == 0);
      force_commit = ($urandom_range(0, 15) == 0);
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
